// File: rtl/wb_merge.sv
// rtl/wb_merge.sv - writeback merge of unstalled ALU results and FIFO-buffered load returns
// Optional macro WB_LD_BYPASS_EN lets a load skip the empty FIFO when the ALU is idle.
module wb_merge #(
   parameter int DATA_WIDTH    = 16,
   parameter int REGADDR_WIDTH = 3,
   parameter int DEPTH         = 4,
   parameter int CNT_WIDTH     = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     alu_valid,
   input  logic [REGADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [REGADDR_WIDTH-1:0] ld_rd,
   input  logic [DATA_WIDTH-1:0]    ld_data,
   output logic                     reg_write,
   output logic [REGADDR_WIDTH-1:0] write_reg,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic [CNT_WIDTH-1:0]     ld_count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic                     r_live [DEPTH];
   logic [REGADDR_WIDTH-1:0] r_rd   [DEPTH];
   logic [DATA_WIDTH-1:0]    r_data [DEPTH];
   logic [PTR_W-1:0]         r_wptr;
   logic [PTR_W-1:0]         r_rptr;
   logic [CNT_WIDTH-1:0]     r_count;
   logic                     r_reg_write;
   logic [REGADDR_WIDTH-1:0] r_write_reg;
   logic [DATA_WIDTH-1:0]    r_write_data;

   logic w_full;
   logic w_empty;
   logic w_ld_fire;
   logic w_bypass;
   logic w_push;
   logic w_pop;
   logic w_same_rd;

   assign w_full    = (r_count == CNT_WIDTH'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign ld_ready  = reset_n & ~w_full;
   assign w_ld_fire = ld_valid & ld_ready;
   assign w_same_rd = alu_valid & (ld_rd == alu_rd);

`ifdef WB_LD_BYPASS_EN
   assign w_bypass = w_ld_fire & ~alu_valid & w_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_ld_fire & ~w_bypass;
   assign w_pop  = ~alu_valid & ~w_empty;

   // The ALU write is younger than everything buffered, so it kills matching entries;
   // the push slot is written after the kill loop so a same-cycle load gets its own live bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_live[i] <= 1'b0;
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (alu_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_rd[i] == alu_rd) begin
                  r_live[i] <= 1'b0;
               end
            end
         end
         if (w_push) begin
            r_live[r_wptr] <= ~w_same_rd;
            r_rd[r_wptr]   <= ld_rd;
            r_data[r_wptr] <= ld_data;
            r_wptr         <= r_wptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_WIDTH'(1);
            2'b01:   r_count <= r_count - CNT_WIDTH'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_reg_write  <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
      end else if (alu_valid) begin
         r_reg_write  <= 1'b1;
         r_write_reg  <= alu_rd;
         r_write_data <= alu_data;
      end else if (!w_empty) begin
         r_reg_write <= r_live[r_rptr];
         if (r_live[r_rptr]) begin
            r_write_reg  <= r_rd[r_rptr];
            r_write_data <= r_data[r_rptr];
         end
      end else if (w_bypass) begin
         r_reg_write  <= 1'b1;
         r_write_reg  <= ld_rd;
         r_write_data <= ld_data;
      end else begin
         r_reg_write <= 1'b0;
      end
   end

   assign reg_write  = r_reg_write;
   assign write_reg  = r_write_reg;
   assign write_data = r_write_data;
   assign ld_count   = r_count;

endmodule

// File: tb/tb_wb_merge.sv
// tb/tb_wb_merge.sv - directed self-checking bench for wb_merge
// Expectations for the bypass case follow WB_LD_BYPASS_EN.
module tb_wb_merge;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic [2:0]  alu_rd = '0;
   logic [15:0] alu_data = '0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [2:0]  ld_rd = '0;
   logic [15:0] ld_data = '0;
   logic        reg_write;
   logic [2:0]  write_reg;
   logic [15:0] write_data;
   logic [2:0]  ld_count;

   int n_checks = 0;
   int n_fail   = 0;

   wb_merge #(
      .DATA_WIDTH(16), .REGADDR_WIDTH(3), .DEPTH(4), .CNT_WIDTH(3)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
      .ld_count(ld_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [2:0] ard, input logic [15:0] adat,
                        input logic lv, input logic [2:0] lrd, input logic [15:0] ldat);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = adat;
      ld_valid  = lv;
      ld_rd     = lrd;
      ld_data   = ldat;
   endtask

   task automatic expect_out(input string tag, input logic we, input logic [2:0] rd,
                             input logic [15:0] dat, input logic [2:0] cnt);
      check({tag, ".reg_write"}, reg_write, we);
      check({tag, ".write_reg"}, write_reg, rd);
      check({tag, ".write_data"}, write_data, dat);
      check({tag, ".ld_count"}, ld_count, cnt);
   endtask

   initial begin
      int acc;

      // reset held with random inputs
      for (int k = 0; k < 4; k++) begin
         drive(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
         tick();
         expect_out("rst", 1'b0, 3'd0, 16'h0, 3'd0);
         check("rst.ld_ready", ld_ready, 1'b0);
      end
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      reset_n = 1'b1;
      #1;
      check("post_rst.ld_ready", ld_ready, 1'b1);
      tick();

      // ALU only
      drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
      tick();
      expect_out("alu.n1", 1'b1, 3'd3, 16'h1234, 3'd0);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      tick();
      expect_out("alu.n2", 1'b0, 3'd3, 16'h1234, 3'd0);

      // ALU priority while loads fill the FIFO
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 3'd7, 16'h0100 + 16'(k), 1'b1, 3'(acc + 1), 16'hD001 + 16'(acc));
         check($sformatf("fill.ready%0d", k), ld_ready, (k < 4) ? 1'b1 : 1'b0);
         tick();
         if (k < 4) acc++;
         expect_out($sformatf("fill.c%0d", k), 1'b1, 3'd7, 16'h0100 + 16'(k), 3'(acc));
      end
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hD005);
      check("drain.full_pop_ready", ld_ready, 1'b0);
      tick();
      expect_out("drain.r1", 1'b1, 3'd1, 16'hD001, 3'd3);
      check("drain.ready_back", ld_ready, 1'b1);
      tick();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      expect_out("drain.r2", 1'b1, 3'd2, 16'hD002, 3'd3);
      tick();
      expect_out("drain.r3", 1'b1, 3'd3, 16'hD003, 3'd2);
      tick();
      expect_out("drain.r4", 1'b1, 3'd4, 16'hD004, 3'd1);
      tick();
      expect_out("drain.r5", 1'b1, 3'd5, 16'hD005, 3'd0);
      tick();
      expect_out("drain.idle", 1'b0, 3'd5, 16'hD005, 3'd0);

      // kill a queued load by a younger ALU write
      drive(1'b1, 3'd0, 16'h0000, 1'b1, 3'd2, 16'hAAAA);
      tick();
      expect_out("kill.q", 1'b1, 3'd0, 16'h0000, 3'd1);
      drive(1'b1, 3'd2, 16'h5555, 1'b0, 3'd0, 16'h0);
      tick();
      expect_out("kill.alu", 1'b1, 3'd2, 16'h5555, 3'd1);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      tick();
      expect_out("kill.pop", 1'b0, 3'd2, 16'h5555, 3'd0);
      tick();
      expect_out("kill.idle", 1'b0, 3'd2, 16'h5555, 3'd0);

      // same-cycle collision on r6
      drive(1'b1, 3'd6, 16'h6666, 1'b1, 3'd6, 16'h0BAD);
      tick();
      expect_out("coll.alu", 1'b1, 3'd6, 16'h6666, 3'd1);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      tick();
      expect_out("coll.pop", 1'b0, 3'd6, 16'h6666, 3'd0);

      // lone load into an empty FIFO
      drive(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h00FF);
      tick();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef WB_LD_BYPASS_EN
      expect_out("byp.n1", 1'b1, 3'd1, 16'h00FF, 3'd0);
      tick();
      expect_out("byp.n2", 1'b0, 3'd1, 16'h00FF, 3'd0);
`else
      expect_out("byp.n1", 1'b0, 3'd6, 16'h6666, 3'd1);
      tick();
      expect_out("byp.n2", 1'b1, 3'd1, 16'h00FF, 3'd0);
`endif

      // reset mid-operation drops buffered loads
      drive(1'b1, 3'd0, 16'h0001, 1'b1, 3'd3, 16'h3333);
      tick();
      expect_out("mrst.q", 1'b1, 3'd0, 16'h0001, 3'd1);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
      reset_n = 1'b0;
      #1;
      expect_out("mrst.async", 1'b0, 3'd0, 16'h0, 3'd0);
      check("mrst.ld_ready", ld_ready, 1'b0);
      reset_n = 1'b1;
      tick();
      expect_out("mrst.after", 1'b0, 3'd0, 16'h0, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
